// File: rtl/piso_tx_scheduler_if.sv
// Request-side handshake and serial-side framing signals of the shared PISO scheduler.
// The scheduler uses the slave view; the word producers and line driver use the master view.
interface piso_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     serial_out;
  logic                     frame_valid;
  logic                     frame_start;
  logic [ID_W-1:0]          frame_id;
  logic                     busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, serial_out, frame_valid, frame_start, frame_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, serial_out, frame_valid, frame_start, frame_id, busy
  );
endinterface

// File: rtl/piso_tx_scheduler.sv
// Round-robin arbiter feeding one shared parallel-in/serial-out shifter, with
// per-frame start/valid strobes and an optional idle gap after every word.
module piso_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bit_tick,
  piso_tx_scheduler_if.slave bus
);
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W   = $clog2(WIDTH);
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int OUT_BIT = (LSB_FIRST != 0) ? 0 : WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [ID_W-1:0]     frame_id_q, frame_id_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic                serial_q, serial_d;
  logic                frame_valid_q, frame_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                busy_q, busy_d;
  logic [NUM_REQ-1:0]  ready_c;
  logic [ID_W:0]       pick_c;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_idx;

  // Scans from last+NUM_REQ down to last+1 so the nearest requester after the
  // previous grant is the final (winning) assignment.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (valid[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] s);
    return (LSB_FIRST != 0) ? (s >> 1) : (s << 1);
  endfunction

  assign pick_c    = rr_pick(bus.req_valid, last_grant_q);
  assign grant_vld = pick_c[ID_W];
  assign grant_idx = pick_c[ID_W-1:0];

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frame_id_d   = frame_id_q;
    last_grant_d = last_grant_q;
    ready_c      = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld && !reset) begin
          ready_c[grant_idx] = 1'b1;
          shift_d            = bus.req_data[int'(grant_idx)*WIDTH +: WIDTH];
          frame_id_d         = grant_idx;
          last_grant_d       = grant_idx;
          bit_cnt_d          = '0;
          state_d            = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_tick) begin
          shift_d = shift_toward_out(shift_q);
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (int'(gap_cnt_q) >= GAP_CYCLES - 1) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output strobes are computed from next-state values so they are true flops
  // yet line up with the state they describe.
  always_comb begin
    serial_d      = (state_d == SHIFT) ? shift_d[OUT_BIT] : 1'b0;
    frame_valid_d = (state_d == SHIFT);
    frame_start_d = (state_d == SHIFT) && (bit_cnt_d == '0);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      frame_id_q    <= '0;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      serial_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_id_q    <= frame_id_d;
      last_grant_q  <= last_grant_d;
      serial_q      <= serial_d;
      frame_valid_q <= frame_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.serial_out  = serial_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_id    = frame_id_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: a queue-based frame model checks every cycle of the
// default instance; a second instance (MSB first, no gap) gets literal checks.
module tb_piso_tx_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int GAP_A   = 1;

  logic clock = 1'b0;
  logic reset;
  logic tick_a, tick_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  piso_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus_a ();
  piso_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus_b ();

  piso_tx_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .GAP_CYCLES(GAP_A), .LSB_FIRST(1)) dut_a (
    .clock(clock), .reset(reset), .bit_tick(tick_a), .bus(bus_a.slave));

  piso_tx_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .GAP_CYCLES(0), .LSB_FIRST(0)) dut_b (
    .clock(clock), .reset(reset), .bit_tick(tick_b), .bus(bus_b.slave));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Model: a frame is the queue of bits still to be sent; the gap is a countdown.
  bit m_bits[$];
  int m_sent = 0, m_gap = 0, m_id = 0, m_last = NUM_REQ - 1;
  bit model_en = 1'b0;

  always @(negedge clock) begin
    logic [NUM_REQ-1:0] er;
    logic [WIDTH-1:0]   w;
    bit                 fr;
    int                 g;
    if (model_en) begin
      fr = (m_bits.size() != 0);
      g  = pick(bus_a.req_valid, m_last);
      er = '0;
      if (!reset && !fr && m_gap == 0 && g >= 0) er[g] = 1'b1;
      check("m_ready",  bus_a.req_ready, er);
      check("m_serial", bus_a.serial_out, fr ? m_bits[0] : 1'b0);
      check("m_fvalid", bus_a.frame_valid, fr);
      check("m_fstart", bus_a.frame_start, fr && m_sent == 0);
      check("m_busy",   bus_a.busy, fr || m_gap > 0);
      check("m_id",     bus_a.frame_id, m_id);
      if (reset) begin
        m_bits.delete(); m_sent = 0; m_gap = 0; m_id = 0; m_last = NUM_REQ - 1;
      end else if (fr) begin
        if (tick_a) begin
          void'(m_bits.pop_front());
          m_sent++;
          if (m_bits.size() == 0) m_gap = GAP_A;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (g >= 0) begin
        w = bus_a.req_data[g*WIDTH +: WIDTH];
        for (int i = 0; i < WIDTH; i++) m_bits.push_back(w[i]);
        m_id = g; m_last = g; m_sent = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  logic             t1_bits[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic             t3_bits[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic             t5_bits[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [NUM_REQ-1:0] acc;
  logic [31:0]        e;
  int                 tick_k;

  initial begin
    reset = 1'b1;
    tick_a = 1'b0; tick_b = 1'b0;
    bus_a.req_valid = '0; bus_a.req_data = '0;
    bus_b.req_valid = '0; bus_b.req_data = '0;
    cyc(); cyc();
    model_en = 1'b1;
    cyc();
    check("rst_busy",   bus_a.busy, 1'b0);
    check("rst_serial", bus_a.serial_out, 1'b0);
    check("rst_ready",  bus_a.req_ready, 4'b0000);
    reset = 1'b0;

    // Single requester 1, word 1011, tick always high.
    bus_a.req_valid = 4'b0010;
    bus_a.req_data  = {4'h0, 4'h0, 4'b1011, 4'h0};
    tick_a = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clock);
      if (c == 0) check("t1_ready", bus_a.req_ready, 4'b0010);
      if (c >= 1 && c <= 4) begin
        check("t1_bit", bus_a.serial_out, t1_bits[c-1]);
        check("t1_id",  bus_a.frame_id, 2'd1);
      end
      check("t1_start",  bus_a.frame_start, c == 1);
      check("t1_fvalid", bus_a.frame_valid, c >= 1 && c <= 4);
      check("t1_busy",   bus_a.busy, c >= 1 && c <= 5);
      cyc();
      if (c == 0) bus_a.req_valid = '0;
    end
    check("t1_id_hold", bus_a.frame_id, 2'd1);

    // All four continuously valid: grants rotate 0,1,2,3,0 every 6 cycles.
    pulse_reset();
    bus_a.req_valid = 4'b1111;
    bus_a.req_data  = $urandom();
    for (int c = 0; c <= 24; c++) begin
      @(negedge clock);
      e = (c % 6 == 0) ? (32'd1 << ((c / 6) % 4)) : 32'd0;
      check("t2_ready", bus_a.req_ready, e);
      acc = bus_a.req_ready & bus_a.req_valid;
      cyc();
      for (int i = 0; i < NUM_REQ; i++)
        if (acc[i]) bus_a.req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom());
    end
    bus_a.req_valid = '0;
    repeat (8) cyc();

    // Reset on the second bit of a requester-2 frame, with 0 and 2 then valid.
    pulse_reset();
    bus_a.req_valid = 4'b0100;
    bus_a.req_data  = $urandom();
    @(negedge clock);
    check("t4_ready", bus_a.req_ready, 4'b0100);
    cyc();
    bus_a.req_valid = '0;
    cyc();
    reset = 1'b1;
    bus_a.req_valid = 4'b0101;
    @(negedge clock);
    check("t4_bit2_fvalid", bus_a.frame_valid, 1'b1);
    check("t4_ready_rst", bus_a.req_ready, 4'b0000);
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("t4_serial", bus_a.serial_out, 1'b0);
    check("t4_fvalid", bus_a.frame_valid, 1'b0);
    check("t4_busy",   bus_a.busy, 1'b0);
    check("t4_id",     bus_a.frame_id, 2'd0);
    check("t4_regrant", bus_a.req_ready, 4'b0001);
    cyc();
    bus_a.req_valid = '0;
    repeat (8) cyc();

    // Tick every third cycle, requester 3 word 0110: each bit held 3 cycles.
    bus_a.req_valid = 4'b1000;
    bus_a.req_data  = {4'b0110, 4'h0, 4'h0, 4'h0};
    tick_a = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clock);
      if (c == 0) check("t3_ready", bus_a.req_ready, 4'b1000);
      if (c >= 1 && c <= 12) check("t3_bit", bus_a.serial_out, t3_bits[(c-1)/3]);
      if (c >= 1) check("t3_fvalid", bus_a.frame_valid, c <= 12);
      cyc();
      if (c == 0) bus_a.req_valid = '0;
      tick_a = ((c + 1) % 3 == 0);
    end
    repeat (3) cyc();

    // Randomized traffic: valid/data hold until accepted, occasional legal drops,
    // varying tick density and sporadic resets.
    tick_k = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      acc = bus_a.req_ready & bus_a.req_valid;
      cyc();
      if (c % 500 == 0) tick_k = $urandom_range(0, 3);
      tick_a = ($urandom_range(0, tick_k) == 0);
      reset  = reset ? 1'b0 : ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          bus_a.req_valid[i] = ($urandom_range(0, 1) == 1);
          bus_a.req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom());
        end else if (bus_a.req_valid[i]) begin
          if ($urandom_range(0, 39) == 0) bus_a.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          bus_a.req_valid[i] = 1'b1;
          bus_a.req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom());
        end
      end
    end
    bus_a.req_valid = '0;
    reset = 1'b0;
    repeat (2) cyc();

    // MSB-first instance, word 1000 from requester 0.
    pulse_reset();
    tick_b = 1'b1;
    bus_b.req_valid = 4'b0001;
    bus_b.req_data  = {4'h0, 4'h0, 4'h0, 4'b1000};
    for (int c = 0; c <= 5; c++) begin
      @(negedge clock);
      if (c == 0) check("t5_ready", bus_b.req_ready, 4'b0001);
      if (c >= 1 && c <= 4) check("t5_bit", bus_b.serial_out, t5_bits[c-1]);
      if (c == 5) check("t5_busy", bus_b.busy, 1'b0);
      cyc();
      if (c == 0) bus_b.req_valid = '0;
    end

    // No gap: requesters 0 and 1 valid, accepts every 5 cycles.
    pulse_reset();
    bus_b.req_valid = 4'b0011;
    bus_b.req_data  = $urandom();
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      e = (c == 5) ? 32'd2 : ((c % 5 == 0) ? 32'd1 : 32'd0);
      check("t6_ready",  bus_b.req_ready, e);
      check("t6_fvalid", bus_b.frame_valid, c % 5 != 0);
      cyc();
    end
    bus_b.req_valid = '0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
